// File: rtl/reg_bus_adapter.sv
// Valid/ready bus to register-field strobe adapter: one transaction at a time, IDLE -> ACCESS -> RESP.
// Optional word-index range check enabled by defining REG_ADAPTER_RANGE_CHECK_EN.
module reg_bus_adapter #(
    parameter int          AW            = 8,
    parameter int          DW            = 32,
    parameter bit          ALLOW_PARTIAL = 1'b0,
    parameter int unsigned NUM_REGS      = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_write_i,
    input  logic [AW-1:0]   req_addr_i,
    input  logic [DW-1:0]   req_wdata_i,
    input  logic [DW/8-1:0] req_be_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_rdata_o,
    output logic            rsp_err_o,
    output logic            reg_we_o,
    output logic            reg_re_o,
    output logic [AW-1:0]   reg_addr_o,
    output logic [DW-1:0]   reg_wdata_o,
    output logic [DW/8-1:0] reg_be_o,
    input  logic [DW-1:0]   reg_rdata_i,
    input  logic            reg_error_i
);

    localparam int BW  = DW / 8;
    localparam int OFF = $clog2(BW);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_next;
    logic   accept, misaligned, partial, range_err, pre_err;
    logic   pre_err_q, write_q;
    logic   ready_d, we_d, re_d, rsp_valid_d;

    assign accept     = req_valid_i & req_ready_o & (state == IDLE);
    assign misaligned = |req_addr_i[OFF-1:0];
    assign partial    = req_write_i & ~(&req_be_i) & ~ALLOW_PARTIAL;

`ifdef REG_ADAPTER_RANGE_CHECK_EN
    logic [AW-1:0] word_idx;
    assign word_idx  = req_addr_i >> OFF;
    assign range_err = (32'(word_idx) >= NUM_REGS);
`else
    logic unused_num_regs;
    assign unused_num_regs = (NUM_REGS == 0);
    assign range_err       = 1'b0;
`endif

    assign pre_err = misaligned | partial | range_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (rsp_valid_o & rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are registered so they land exactly in the ACCESS cycle.
    always_comb begin
        ready_d     = (state_next == IDLE);
        we_d        = accept & req_write_i & ~pre_err;
        re_d        = accept & ~req_write_i & ~pre_err;
        rsp_valid_d = (state_next == RESP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_ready_o <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            rsp_valid_o <= 1'b0;
        end else begin
            req_ready_o <= ready_d;
            reg_we_o    <= we_d;
            reg_re_o    <= re_d;
            rsp_valid_o <= rsp_valid_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_be_o    <= '0;
            write_q     <= 1'b0;
            pre_err_q   <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            if (accept) begin
                reg_addr_o  <= req_addr_i;
                reg_wdata_o <= req_wdata_i;
                reg_be_o    <= req_be_i;
                write_q     <= req_write_i;
                pre_err_q   <= pre_err;
            end
            // Response is frozen at the end of ACCESS and held through RESP.
            if (state == ACCESS) begin
                rsp_err_o <= pre_err_q | ((reg_we_o | reg_re_o) & reg_error_i);
                if (pre_err_q)    rsp_rdata_o <= '1;
                else if (write_q) rsp_rdata_o <= '0;
                else              rsp_rdata_o <= reg_rdata_i;
            end
        end
    end

endmodule

// File: doc/reg_bus_adapter.md
Name: reg_bus_adapter

Overview:
- Bus-side initiator for register fields. Converts a valid/ready request/response bus into the single-cycle write-enable, write-data, byte-enable and read-enable strobes that register fields consume.
- Returns each field's read-back value (qs) and error status to the bus master.
- Sits between the peripheral bus interconnect and a register file built from register-field instances.
- Handles one transaction at a time. Checks alignment and partial writes before any strobe is issued.

Parameters:
- AW, 8, byte address width.
- DW, 32, data width; must be a multiple of 8, minimum 16.
- ALLOW_PARTIAL, 0, when 1, writes with partial byte enables are forwarded; when 0, they are rejected with an error.
- NUM_REGS, 64, number of DW-wide registers; used only by the optional range check.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  adapter can accept a request
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  AW  byte address
- req_wdata_i  in  DW  write data
- req_be_i  in  DW/8  byte enables
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  master accepts response
- rsp_rdata_o  out  DW  read data
- rsp_err_o  out  1  transaction error
- reg_we_o  out  1  write strobe to register fields
- reg_re_o  out  1  read strobe to register fields
- reg_addr_o  out  AW  registered byte address
- reg_wdata_o  out  DW  registered write data
- reg_be_o  out  DW/8  registered byte enables
- reg_rdata_i  in  DW  combinational read-back data (qs mux) from the register file
- reg_error_i  in  1  register file decode error, valid while reg_we_o or reg_re_o is high

Behaviour:
- Reset (async, rst_ni low): every output is 0, state is IDLE. req_ready_o is a flop and rises the first clock after reset release. Asserting reset mid-transaction drops the transaction; no strobe and no response are issued for it.
- States:
  - IDLE: req_ready_o=1. On req_valid_i & req_ready_o (cycle N), capture addr, wdata, be and write into the reg_* output flops and compute the pre-error. Go to ACCESS; req_ready_o=0 from N+1.
  - ACCESS (cycle N+1):
    - If no pre-error: reg_we_o (write) or reg_re_o (read) is high for exactly this one cycle.
    - Read: reg_rdata_i is sampled at the end of this cycle into rsp_rdata_o. Write: rsp_rdata_o is set to 0.
    - rsp_err_o is set to the pre-error OR (reg_error_i while a strobe is high).
    - If there is a pre-error: no strobe is issued and rsp_rdata_o is all ones.
    - Always go to RESP.
  - RESP (cycle N+2 onward): rsp_valid_o=1. rsp_rdata_o and rsp_err_o are held stable until rsp_valid_o & rsp_ready_i. On that handshake, clear rsp_valid_o and go to IDLE; req_ready_o is high the following cycle.
- Pre-error conditions:
  - Misaligned address: any of the low clog2(DW/8) bits of req_addr_i nonzero.
  - Write with req_be_i not all ones when ALLOW_PARTIAL=0.
  - Reads ignore req_be_i.
  - Range error (only with the optional feature enabled).
- Minimum cost is 3 cycles per transaction. Requests presented while req_ready_o=0 are not accepted; the master must hold them.
- reg_we_o and reg_re_o are never high together and are never high outside ACCESS.
- reg_addr_o, reg_wdata_o and reg_be_o hold their last captured values between transactions.
- rsp_ready_i held high constantly means the response completes in one cycle. rsp_ready_i held low means the adapter stalls in RESP indefinitely.

Optional Feature:
- Macro REG_ADAPTER_RANGE_CHECK_EN.
- Defined: word index (req_addr_i >> clog2(DW/8)) >= NUM_REGS is a pre-error. No strobe is issued; the response is rsp_err_o=1 with rsp_rdata_o all ones.
- Undefined: no range check; out-of-range accesses are forwarded and rely on reg_error_i.

Test Plan:
- Reset then idle: rst_ni low for 3 cycles -> all outputs 0; req_ready_o=1 one cycle after release.
- Aligned write addr=0x08, wdata=0xDEADBEEF, be=0xF, rsp_ready_i=1 -> reg_we_o high exactly at N+1 with reg_addr_o=0x08 and reg_wdata_o=0xDEADBEEF; rsp_valid_o at N+2 with rsp_err_o=0; req_ready_o high at N+3.
- Read addr=0x04 with reg_rdata_i=0x12345678 during ACCESS and rsp_ready_i low for 4 cycles -> reg_re_o pulses once; rsp_rdata_o=0x12345678 held stable through the stall; handshake on the 5th RESP cycle.
- Misaligned write addr=0x06, and partial write be=0x3 with ALLOW_PARTIAL=0 -> no reg_we_o; rsp_err_o=1; rsp_rdata_o=0xFFFFFFFF. Same partial write with ALLOW_PARTIAL=1 -> reg_we_o pulses with reg_be_o=0x3.
- Read where reg_error_i=1 during ACCESS -> rsp_err_o=1; with REG_ADAPTER_RANGE_CHECK_EN and NUM_REGS=4, read addr=0x10 -> no reg_re_o, rsp_err_o=1.
- Reset asserted during ACCESS of a write -> reg_we_o drops immediately; no rsp_valid_o after release; the next request completes normally.
